// File: rtl/sysbus_arbiter.sv
// Two-requester Sysbus arbiter: round-robin request grant, requester index stamped
// into the request tag, response beats steered back to their owner by tag bit 0.
`timescale 1ns/1ps
module sysbus_arbiter #(
   parameter int unsigned TAGW  = 13,
   parameter int unsigned BEATS = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            r0_reqcyc,
   input  logic [63:0]     r0_req,
   input  logic [TAGW-1:0] r0_reqtag,
   output logic            r0_reqack,
   output logic            r0_respcyc,
   input  logic            r0_respack,
   input  logic            r1_reqcyc,
   input  logic [63:0]     r1_req,
   input  logic [TAGW-1:0] r1_reqtag,
   output logic            r1_reqack,
   output logic            r1_respcyc,
   input  logic            r1_respack,
   output logic [63:0]     resp_data,
   output logic [TAGW-1:0] resp_tag,
   output logic            bus_reqcyc,
   output logic [63:0]     bus_req,
   output logic [TAGW-1:0] bus_reqtag,
   input  logic            bus_reqack,
   input  logic            bus_respcyc,
   input  logic [63:0]     bus_resp,
   input  logic [TAGW-1:0] bus_resptag,
   output logic            bus_respack
);

   localparam int unsigned CNTW = $clog2(BEATS) + 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_q, state_d;
   logic            grant_q, grant_d;
   logic            last_grant_q, last_grant_d;
   logic [1:0]      pend_q, pend_d;
   logic [CNTW-1:0] beat_cnt_q, beat_cnt_d;

   logic [1:0]      elig;
   logic            busy;
   logic            gnt_reqcyc;
   logic [63:0]     gnt_req;
   logic [TAGW-9:0] gnt_tag_hi;
   logic            gnt_read;
   logic            owner;
   logic            owner_respack;
   logic            beat_done;
   logic            last_beat;
   logic            req_ack;

   // Requester id bits and the upper response tag bits play no part in routing.
   logic unused_tag_bits;
   assign unused_tag_bits = ^{r0_reqtag[7:0], r1_reqtag[7:0], bus_resptag[TAGW-1:1]};

   assign busy          = (state_q == BUSY);
   assign elig          = {r1_reqcyc & ~pend_q[1], r0_reqcyc & ~pend_q[0]};
   assign gnt_reqcyc    = grant_q ? r1_reqcyc : r0_reqcyc;
   assign gnt_req       = grant_q ? r1_req : r0_req;
   assign gnt_tag_hi    = grant_q ? r1_reqtag[TAGW-1:8] : r0_reqtag[TAGW-1:8];
   assign gnt_read      = gnt_tag_hi[TAGW-9];
   assign owner         = bus_resptag[0];
   assign owner_respack = owner ? r1_respack : r0_respack;
   assign beat_done     = bus_respcyc & owner_respack;
   assign last_beat     = beat_done && (beat_cnt_q == CNTW'(BEATS - 1));
   assign req_ack       = busy & gnt_reqcyc & bus_reqack;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         pend_q       <= '0;
         beat_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         pend_q       <= pend_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      unique case (state_q)
         IDLE: begin
            if (elig != 2'b00) begin
               state_d = BUSY;
               grant_d = (elig == 2'b11) ? ~last_grant_q : elig[1];
            end
         end
         BUSY: begin
            // Grant is held until the owner drops reqcyc, covering write data beats.
            if (!gnt_reqcyc) begin
               state_d      = IDLE;
               last_grant_d = grant_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pend_d     = pend_q;
      beat_cnt_d = beat_cnt_q;
      if (beat_done) begin
         beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
      end
      if (last_beat) begin
         pend_d[owner] = 1'b0;
      end
      if (req_ack && gnt_read) begin
         pend_d[grant_q] = 1'b1;
      end
   end

   always_comb begin
      bus_reqcyc  = ~reset & busy & gnt_reqcyc;
      bus_req     = reset ? '0 : gnt_req;
      bus_reqtag  = reset ? '0 : {gnt_tag_hi, 7'b0, grant_q};
      r0_reqack   = ~reset & busy & ~grant_q & bus_reqack;
      r1_reqack   = ~reset & busy &  grant_q & bus_reqack;
      r0_respcyc  = ~reset & bus_respcyc & ~owner;
      r1_respcyc  = ~reset & bus_respcyc &  owner;
      bus_respack = ~reset & owner_respack;
      resp_data   = reset ? '0 : bus_resp;
      resp_tag    = reset ? '0 : bus_resptag;
   end

   resp_owner_pending: assert property (@(posedge clk) disable iff (reset)
      bus_respcyc |-> pend_q[owner])
      else $fatal(1, "sysbus_arbiter: response beat for requester %0d with no read outstanding", owner);

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Bench for sysbus_arbiter: plays both requesters and the Sysbus slave; bus beats
// and response beats are checked against scoreboards filled as stimulus is driven.
`timescale 1ns/1ps
module tb_sysbus_arbiter;

   localparam int TAGW  = 13;
   localparam int BEATS = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic            r0_reqcyc, r1_reqcyc, r0_respack, r1_respack;
   logic [63:0]     r0_req, r1_req;
   logic [TAGW-1:0] r0_reqtag, r1_reqtag;
   logic            r0_reqack, r1_reqack, r0_respcyc, r1_respcyc;
   logic [63:0]     resp_data, bus_req, bus_resp;
   logic [TAGW-1:0] resp_tag, bus_reqtag, bus_resptag;
   logic            bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;

   typedef struct packed {logic [63:0] data; logic [TAGW-1:0] tag;} req_exp_t;
   typedef struct packed {logic owner; logic [63:0] data; logic [TAGW-1:0] tag;} resp_exp_t;

   req_exp_t    q0[$], q1[$];
   resp_exp_t   rq[$];
   req_exp_t    me;
   resp_exp_t   mr;
   int unsigned vecs = 0;
   int unsigned errs = 0;

   sysbus_arbiter #(.TAGW(TAGW), .BEATS(BEATS)) dut (
      .clk(clk), .reset(reset),
      .r0_reqcyc(r0_reqcyc), .r0_req(r0_req), .r0_reqtag(r0_reqtag), .r0_reqack(r0_reqack),
      .r0_respcyc(r0_respcyc), .r0_respack(r0_respack),
      .r1_reqcyc(r1_reqcyc), .r1_req(r1_req), .r1_reqtag(r1_reqtag), .r1_reqack(r1_reqack),
      .r1_respcyc(r1_respcyc), .r1_respack(r1_respack),
      .resp_data(resp_data), .resp_tag(resp_tag),
      .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
      .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
      .bus_respack(bus_respack)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Request scoreboard: every accepted bus beat must match the oldest beat its requester drove.
   always @(negedge clk) begin
      if (!reset && bus_reqcyc && bus_reqack) begin
         vecs++;
         if ((bus_reqtag[0] ? q1.size() : q0.size()) == 0) begin
            errs++;
            $display("FAIL req_sb: unexpected bus beat req=%h tag=%h", bus_req, bus_reqtag);
         end else begin
            me = bus_reqtag[0] ? q1.pop_front() : q0.pop_front();
            if ({bus_req, bus_reqtag} !== {me.data, me.tag}) begin
               errs++;
               $display("FAIL req_sb: req=%h tag=%h exp req=%h tag=%h", bus_req, bus_reqtag, me.data, me.tag);
            end
            vecs++;
            if ({r1_reqack, r0_reqack} !== (me.tag[0] ? 2'b10 : 2'b01)) begin
               errs++;
               $display("FAIL reqack_route: {r1,r0}_reqack=%b exp owner r%0d only", {r1_reqack, r0_reqack}, me.tag[0]);
            end
         end
      end
      if (!reset && bus_respcyc && bus_respack) begin
         vecs++;
         if (rq.size() == 0) begin
            errs++;
            $display("FAIL resp_sb: unexpected response beat data=%h", resp_data);
         end else begin
            mr = rq.pop_front();
            if ({resp_data, resp_tag} !== {mr.data, mr.tag}) begin
               errs++;
               $display("FAIL resp_sb: data=%h tag=%h exp data=%h tag=%h", resp_data, resp_tag, mr.data, mr.tag);
            end
            vecs++;
            if ({r1_respcyc, r0_respcyc} !== (mr.owner ? 2'b10 : 2'b01)) begin
               errs++;
               $display("FAIL respcyc_route: {r1,r0}_respcyc=%b exp owner r%0d only", {r1_respcyc, r0_respcyc}, mr.owner);
            end
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   function automatic logic [63:0] wdata(input int r, input int b);
      return 64'hD0D0_0000_0000_0000 | (64'(r) << 8) | 64'(b);
   endfunction

   task automatic clear_inputs();
      r0_reqcyc = 0; r0_req = '0; r0_reqtag = '0; r0_respack = 1;
      r1_reqcyc = 0; r1_req = '0; r1_reqtag = '0; r1_respack = 1;
      bus_reqack = 0; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;
   endtask

   task automatic do_reset();
      nxt();
      reset = 1;
      clear_inputs();
      nxt();
      nxt();
      q0.delete(); q1.delete(); rq.delete();
      reset = 0;
      smp();
   endtask

   task automatic req_start(input int r, input logic [63:0] addr, input logic [TAGW-1:0] tag);
      req_exp_t e;
      e.data = addr;
      e.tag  = {tag[TAGW-1:8], 7'b0, r[0]};
      if (r == 0) begin
         r0_reqcyc = 1; r0_req = addr; r0_reqtag = tag; q0.push_back(e);
      end else begin
         r1_reqcyc = 1; r1_req = addr; r1_reqtag = tag; q1.push_back(e);
      end
   endtask

   task automatic req_beat(input int r, input logic [63:0] d);
      req_exp_t e;
      e.data = d;
      if (r == 0) begin
         r0_req = d; e.tag = {r0_reqtag[TAGW-1:8], 7'b0, 1'b0}; q0.push_back(e);
      end else begin
         r1_req = d; e.tag = {r1_reqtag[TAGW-1:8], 7'b0, 1'b1}; q1.push_back(e);
      end
   endtask

   task automatic req_stop(input int r);
      if (r == 0) r0_reqcyc = 0;
      else r1_reqcyc = 0;
   endtask

   // Acks nbeats bus beats once r is granted, then drops its reqcyc; returns at a negedge.
   task automatic serve(input int r, input int nbeats);
      int unsigned w = 0;
      while (!(bus_reqcyc === 1'b1 && bus_reqtag[0] === r[0]) && w < 20) begin
         nxt(); smp(); w++;
      end
      vecs++;
      if (w >= 20) begin
         errs++;
         $display("FAIL serve_grant: r%0d not granted within 20 cycles, bus_reqcyc=%b", r, bus_reqcyc);
      end else begin
         for (int b = 0; b < nbeats; b++) begin
            nxt();
            if (b > 0) req_beat(r, wdata(r, b));
            bus_reqack = 1;
            smp();
         end
      end
      nxt();
      bus_reqack = 0;
      req_stop(r);
      smp();
   endtask

   task automatic read_granted(input int r, input logic [63:0] addr);
      nxt();
      req_start(r, addr, 13'h1000);
      smp();
      serve(r, 1);
   endtask

   task automatic drive_beat(input int owner, input int b, input bit push);
      resp_exp_t e;
      bus_respcyc = 1;
      bus_resptag = {1'b1, 11'b0, owner[0]};
      bus_resp    = 64'hB0B0_0000_0000_0000 | (64'(owner) << 16) | 64'(b);
      if (push) begin
         e.owner = owner[0]; e.data = bus_resp; e.tag = bus_resptag;
         rq.push_back(e);
      end
   endtask

   // Sends a BEATS-long read response, optionally stalling the owner's respack.
   task automatic burst(input int owner, input int stall_at, input int stall_len, input bit chk_blk);
      int b = 0;
      int pushed = -1;
      int stall = 0;
      int cyc = 0;
      bit stalling;
      while (b < BEATS && cyc < 64) begin
         nxt();
         cyc++;
         drive_beat(owner, b, pushed != b);
         pushed = b;
         stalling = (b == stall_at) && (stall < stall_len);
         if (owner == 0) r0_respack = !stalling;
         else r1_respack = !stalling;
         smp();
         if (stalling) begin
            stall++;
            vecs++;
            if (bus_respack !== 1'b0 || (owner == 0 ? r0_respcyc : r1_respcyc) !== 1'b1) begin
               errs++;
               $display("FAIL stall_hold: bus_respack=%b respcyc=%b exp 0/1", bus_respack,
                        owner == 0 ? r0_respcyc : r1_respcyc);
            end
         end else begin
            b++;
         end
         if (chk_blk) begin
            vecs++;
            if (bus_reqcyc !== 1'b0) begin
               errs++;
               $display("FAIL pend_block: bus_reqcyc=%b exp 0 during beat %0d", bus_reqcyc, b);
            end
         end
      end
      vecs++;
      if (b < BEATS) begin
         errs++;
         $display("FAIL burst_done: %0d beats completed exp %0d", b, BEATS);
      end
      nxt();
      bus_respcyc = 0; bus_resptag = '0; r0_respack = 1; r1_respack = 1;
      smp();
   endtask

   // After a burst ending with a waiting requester: one IDLE cycle, then that requester's bus cycle.
   task automatic expect_regrant(input int r, input string name);
      vecs++;
      if (bus_reqcyc !== 1'b0) begin
         errs++;
         $display("FAIL %s_idle: bus_reqcyc=%b exp 0", name, bus_reqcyc);
      end
      nxt(); smp();
      vecs++;
      if (bus_reqcyc !== 1'b1 || bus_reqtag[0] !== r[0]) begin
         errs++;
         $display("FAIL %s_grant: bus_reqcyc=%b tag0=%b exp 1/%0d", name, bus_reqcyc, bus_reqtag[0], r);
      end
   endtask

   task automatic test_reset();
      nxt();
      reset = 1;
      r0_reqcyc = 1; r0_req = '1; r0_reqtag = '1; r1_reqcyc = 1; r1_req = '1; r1_reqtag = '1;
      bus_reqack = 1; bus_respcyc = 1; bus_resp = '1; bus_resptag = 13'h1001;
      r0_respack = 1; r1_respack = 1;
      for (int i = 0; i < 2; i++) begin
         if (i > 0) nxt();
         smp();
         vecs++;
         if ({bus_reqcyc, bus_req, bus_reqtag, bus_respack, r0_reqack, r1_reqack, r0_respcyc, r1_respcyc,
              resp_data, resp_tag} !== '0) begin
            errs++;
            $display("FAIL reset_outputs: bus_reqcyc=%b bus_req=%h bus_reqtag=%h bus_respack=%b reqack=%b%b respcyc=%b%b resp_data=%h resp_tag=%h exp all 0",
                     bus_reqcyc, bus_req, bus_reqtag, bus_respack, r1_reqack, r0_reqack, r1_respcyc, r0_respcyc,
                     resp_data, resp_tag);
         end
      end
      nxt();
      reset = 0;
      clear_inputs();
      smp();
      vecs++;
      if ({bus_reqcyc, r0_respcyc, r1_respcyc} !== 3'b000) begin
         errs++;
         $display("FAIL reset_idle: bus_reqcyc=%b respcyc=%b%b exp 000", bus_reqcyc, r1_respcyc, r0_respcyc);
      end
   endtask

   task automatic test_r0_read();
      do_reset();
      nxt();
      req_start(0, 64'h1000, 13'h15AB);
      smp();
      vecs++;
      if (bus_reqcyc !== 1'b0) begin
         errs++; $display("FAIL r0rd_lat0: bus_reqcyc=%b exp 0", bus_reqcyc);
      end
      nxt(); smp();
      vecs++;
      if (bus_reqcyc !== 1'b1 || bus_reqtag !== 13'h1500) begin
         errs++; $display("FAIL r0rd_lat1: bus_reqcyc=%b tag=%h exp 1/1500", bus_reqcyc, bus_reqtag);
      end
      serve(0, 1);
      vecs++;
      if (bus_reqcyc !== 1'b0) begin
         errs++; $display("FAIL r0rd_release: bus_reqcyc=%b exp 0", bus_reqcyc);
      end
      burst(0, BEATS, 0, 1'b0);
      nxt();
      req_start(0, 64'h2000, 13'h0000);
      smp(); nxt(); smp();
      vecs++;
      if (bus_reqcyc !== 1'b1 || bus_reqtag[0] !== 1'b0) begin
         errs++; $display("FAIL r0rd_pendclr: bus_reqcyc=%b tag0=%b exp 1/0", bus_reqcyc, bus_reqtag[0]);
      end
      serve(0, 1);
   endtask

   task automatic test_simultaneous();
      do_reset();
      nxt();
      req_start(0, 64'hA0, 13'h0100);
      req_start(1, 64'hA1, 13'h0200);
      smp(); nxt(); smp();
      vecs++;
      if (bus_reqcyc !== 1'b1 || bus_reqtag[0] !== 1'b0 || bus_req !== 64'hA0) begin
         errs++; $display("FAIL sim_first: bus_reqcyc=%b tag0=%b req=%h exp 1/0/a0", bus_reqcyc, bus_reqtag[0], bus_req);
      end
      serve(0, 1);
      nxt();
      req_start(0, 64'hA2, 13'h0100);
      smp();
      vecs++;
      if (bus_reqcyc !== 1'b0) begin
         errs++; $display("FAIL sim_gap: bus_reqcyc=%b exp 0", bus_reqcyc);
      end
      nxt(); smp();
      vecs++;
      if (bus_reqcyc !== 1'b1 || bus_reqtag[0] !== 1'b1 || bus_req !== 64'hA1) begin
         errs++; $display("FAIL sim_rr: bus_reqcyc=%b tag0=%b req=%h exp 1/1/a1", bus_reqcyc, bus_reqtag[0], bus_req);
      end
      serve(1, 1);
      nxt(); smp();
      expect_regrant(0, "sim_back");
      serve(0, 1);
   endtask

   task automatic test_write_burst();
      do_reset();
      nxt();
      req_start(1, 64'h3000, 13'h03CD);
      smp(); nxt(); smp();
      for (int b = 0; b <= BEATS; b++) begin
         nxt();
         if (b > 0) req_beat(1, wdata(1, b));
         if (b == 3) req_start(0, 64'h4000, 13'h0000);
         bus_reqack = 1;
         smp();
         vecs++;
         if (bus_reqcyc !== 1'b1 || bus_reqtag !== 13'h0301 || r0_reqack !== 1'b0) begin
            errs++;
            $display("FAIL wr_lock: beat %0d bus_reqcyc=%b tag=%h r0_reqack=%b exp 1/0301/0", b, bus_reqcyc, bus_reqtag, r0_reqack);
         end
      end
      nxt();
      bus_reqack = 0;
      req_stop(1);
      smp();
      nxt(); smp();
      expect_regrant(0, "wr_next");
      serve(0, 1);
      nxt();
      req_start(1, 64'h3100, 13'h0300);
      smp(); nxt(); smp();
      vecs++;
      if (bus_reqcyc !== 1'b1 || bus_reqtag[0] !== 1'b1) begin
         errs++; $display("FAIL wr_nopend: bus_reqcyc=%b tag0=%b exp 1/1", bus_reqcyc, bus_reqtag[0]);
      end
      serve(1, 1);
   endtask

   task automatic test_pend_block();
      do_reset();
      read_granted(0, 64'h5000);
      nxt();
      req_start(0, 64'h5040, 13'h1000);
      req_start(1, 64'h6000, 13'h0000);
      smp(); nxt(); smp();
      vecs++;
      if (bus_reqcyc !== 1'b1 || bus_reqtag[0] !== 1'b1) begin
         errs++; $display("FAIL pend_other: bus_reqcyc=%b tag0=%b exp 1/1", bus_reqcyc, bus_reqtag[0]);
      end
      serve(1, 1);
      for (int i = 0; i < 2; i++) begin
         nxt(); smp();
         vecs++;
         if (bus_reqcyc !== 1'b0) begin
            errs++; $display("FAIL pend_wait: bus_reqcyc=%b exp 0", bus_reqcyc);
         end
      end
      burst(0, BEATS, 0, 1'b1);
      expect_regrant(0, "pend_after");
      serve(0, 1);
   endtask

   task automatic test_backpressure();
      do_reset();
      read_granted(0, 64'h7000);
      nxt();
      req_start(0, 64'h7040, 13'h1000);
      smp();
      burst(0, 3, 3, 1'b1);
      expect_regrant(0, "bp_after");
      serve(0, 1);
   endtask

   task automatic test_reset_midburst();
      do_reset();
      read_granted(0, 64'h8800);
      for (int b = 0; b < 3; b++) begin
         nxt(); drive_beat(0, b, 1'b1); smp();
      end
      nxt();
      drive_beat(0, 3, 1'b0);
      r0_reqcyc = 1;
      bus_reqack = 1;
      reset = 1;
      smp();
      vecs++;
      if ({bus_reqcyc, bus_req, bus_reqtag, bus_respack, r0_reqack, r1_reqack, r0_respcyc, r1_respcyc,
           resp_data, resp_tag} !== '0) begin
         errs++;
         $display("FAIL midrst_outputs: bus_reqcyc=%b bus_respack=%b respcyc=%b%b resp_data=%h exp all 0",
                  bus_reqcyc, bus_respack, r1_respcyc, r0_respcyc, resp_data);
      end
      nxt();
      reset = 0;
      clear_inputs();
      q0.delete(); q1.delete(); rq.delete();
      smp();
      nxt();
      req_start(1, 64'h8000, 13'h0000);
      smp(); nxt(); smp();
      vecs++;
      if (bus_reqcyc !== 1'b1 || bus_reqtag[0] !== 1'b1) begin
         errs++; $display("FAIL midrst_r1: bus_reqcyc=%b tag0=%b exp 1/1", bus_reqcyc, bus_reqtag[0]);
      end
      serve(1, 1);
      nxt();
      req_start(0, 64'h9000, 13'h1000);
      smp(); nxt(); smp();
      vecs++;
      if (bus_reqcyc !== 1'b1 || bus_reqtag[0] !== 1'b0) begin
         errs++; $display("FAIL midrst_pendclr: bus_reqcyc=%b tag0=%b exp 1/0", bus_reqcyc, bus_reqtag[0]);
      end
      serve(0, 1);
      nxt();
      req_start(0, 64'h9040, 13'h1000);
      smp();
      burst(0, BEATS, 0, 1'b1);
      expect_regrant(0, "midrst_cnt");
      serve(0, 1);
   endtask

   initial begin
      reset = 1;
      clear_inputs();
      test_reset();
      test_r0_read();
      test_simultaneous();
      test_write_burst();
      test_pend_block();
      test_backpressure();
      test_reset_midburst();
      nxt(); smp();
      vecs++;
      if (q0.size() + q1.size() + rq.size() != 0) begin
         errs++;
         $display("FAIL sb_drain: leftover q0=%0d q1=%0d resp=%0d exp 0", q0.size(), q1.size(), rq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/sysbus_arbiter.md
Name: sysbus_arbiter

Overview:
- Shares the single Sysbus master port between two requesters: requester 0 (instruction fetch) and requester 1 (data load/store unit).
- Grants the request channel to one requester at a time, round-robin when both request.
- Stamps the requester index into the request tag.
- Routes each response burst back to its owner by tag.
- Sits between the core's fetch/LSU logic and the top-level Sysbus.

Parameters:
- TAGW, 13, width of reqtag/resptag. The MSB is the READ/WRITE bit (1 = READ). Bits [7:0] are the transaction id field.
- BEATS, 8, number of 64-bit response beats per read (one 64-byte line).

Ports:
- clk  in  1  Sysbus clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset, sampled on posedge clk.
- r0_reqcyc, r1_reqcyc  in  1  requester asserts a request; held until reqack. For writes, held through all data beats.
- r0_req, r1_req  in  64  address, then write data beats.
- r0_reqtag, r1_reqtag  in  TAGW  requester tag; bits [7:0] ignored.
- r0_reqack, r1_reqack  out  1  bus_reqack routed to the granted requester only.
- r0_respcyc, r1_respcyc  out  1  response beat valid for this requester.
- r0_respack, r1_respack  in  1  requester accepts the current beat.
- resp_data  out  64  bus_resp broadcast to both requesters.
- resp_tag  out  TAGW  bus_resptag broadcast to both requesters.
- bus_reqcyc  out  1  request valid to Sysbus.
- bus_req  out  64  muxed request address/data.
- bus_reqtag  out  TAGW  {granted tag[TAGW-1:8], 7'b0, grant index}.
- bus_reqack  in  1  Sysbus accepted the request / beat.
- bus_respcyc  in  1  response beat valid.
- bus_resp  in  64  response data.
- bus_resptag  in  TAGW  response tag.
- bus_respack  out  1  ack from the owner of the current beat.

Behaviour:
- State machine, states IDLE and BUSY. Registers:
  - grant (1b)
  - last_grant (1b)
  - pend[1:0] (outstanding-read flags)
  - beat_cnt ($clog2(BEATS)+1 bits)
- Reset: state=IDLE, grant=0, last_grant=1 (so requester 0 wins first), pend=0, beat_cnt=0.
  - While reset is high, all 1-bit outputs are 0.
  - bus_req, bus_reqtag, resp_data and resp_tag are 0.
  - Reset mid-burst abandons the transaction with no completion signalled.
- Eligibility: requester i is eligible when ri_reqcyc=1 and pend[i]=0.
- IDLE:
  - If exactly one requester is eligible, set grant to it.
  - If both are eligible, grant = ~last_grant.
  - Move to BUSY on the next cycle.
  - bus_reqcyc=0 in IDLE, so request latency is 1 cycle from first ri_reqcyc to bus_reqcyc.
- BUSY:
  - bus_reqcyc = r[grant]_reqcyc; bus_req = r[grant]_req; r[grant]_reqack = bus_reqack; the other requester's reqack=0.
  - On bus_reqack with tag MSB=1 (READ), set pend[grant].
  - When r[grant]_reqcyc=0: go to IDLE next cycle and set last_grant=grant. The grant is therefore locked for the whole write data phase.
  - A requester deasserting reqcyc before ack is legal and releases the grant.
- Response path (independent of state; runs concurrently with a request from the other requester):
  - owner = bus_resptag[0].
  - r[owner]_respcyc = bus_respcyc; bus_respack = r[owner]_respack.
  - A beat completes when bus_respcyc && bus_respack. Each completed beat increments beat_cnt.
  - On the BEATS-th beat (beat_cnt==BEATS-1 at that beat), clear beat_cnt and pend[owner]. The owner may be re-granted a read from the next cycle.
  - A response beat for a requester with pend=0 is a protocol error: assert and $fatal.
  - Simultaneous completion of the last beat and IDLE arbitration: eligibility uses the registered pend (before clear), so that requester waits one more cycle.
- bus_reqtag bits [7:1] are always 0. The arbiter never forwards requester-supplied id bits.

Test Plan:
- r0 read only: r0_reqcyc=1 at cycle 0, addr 0x1000 -> bus_reqcyc=1 at cycle 1 with bus_reqtag[0]=0. When bus_reqack pulses, r0_reqack=1 and r1_reqack=0. pend[0]=1. 8 beats tagged id 0 appear on r0_respcyc with r1_respcyc=0. pend[0] clears after beat 8.
- Simultaneous requests: r0 and r1 both assert from reset -> r0 is served first. When r0 drops reqcyc, r1 is granted 2 cycles later (IDLE then BUSY). A repeated r0 request then waits until r1 releases.
- r1 write with 8 data beats: grant is held for 9 acked beats. r0_reqcyc asserted mid-burst gets no bus_reqcyc until r1_reqcyc falls. pend[1] stays 0.
- Pending-read block: after r0's read is acked, r0 requests again before its response -> no grant. A concurrent r1 request is granted. r0 is granted only after its 8th beat.
- Respack backpressure: r0_respack=0 for 3 cycles mid-burst -> bus_respack=0 and beat_cnt holds. The burst completes after exactly 8 acked beats.
- Reset mid-operation: assert reset during beat 4 -> all outputs 0 next cycle, pend=0, beat_cnt=0. A fresh r1 request is then granted normally.
